// File: rtl/camlink_pkg.sv
// Shared types and elaboration helpers for the Camera Link line packer.
package camlink_pkg;

   typedef enum logic [1:0] {SYNC, IDLE, WAIT_LINE, LINE} state_t;

   // Number of beats that fill one output word.
   function automatic int ratio(input int out_w, input int bw);
      return out_w / bw;
   endfunction

endpackage

// File: rtl/camlink_out_reg.sv
// One-entry valid/ready output register carrying a data word and its start-of-frame flag.
module camlink_out_reg #(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         srst_i,
   input  logic         flush_i,
   input  logic         push_i,
   input  logic [W-1:0] data_i,
   input  logic         sof_i,
   input  logic         ready_i,
   output logic         valid_o,
   output logic [W-1:0] data_o,
   output logic         sof_o,
   output logic         drop_o,
   output logic         overflow_o
);

   logic         valid_q;
   logic [W-1:0] data_q;
   logic         sof_q;
   logic         ovf_q;

   // A push only loses data when the held word is still waiting on the consumer.
   assign drop_o = push_i & valid_q & ~ready_i & ~flush_i;

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         sof_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (flush_i) begin
         valid_q <= 1'b0;
      end else if (push_i && (!valid_q || ready_i)) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
         sof_q   <= sof_i;
      end else if (push_i) begin
         ovf_q   <= 1'b1;
      end else if (ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o    = valid_q;
   assign data_o     = data_q;
   assign sof_o      = sof_q;
   assign overflow_o = ovf_q;

endmodule

// File: rtl/camlink_line_packer.sv
// Camera Link FVAL/LVAL/DVAL framer: packs beats into OUT_W words and reports line/frame statistics.
module camlink_line_packer
   import camlink_pkg::*;
#(
   parameter int PIX_W = 8,
   parameter int TAPS  = 1,
   parameter int OUT_W = 32,
   parameter int CNT_W = 16
) (
   input  logic                  rx_clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  fval,
   input  logic                  lval,
   input  logic                  dval,
   input  logic [PIX_W*TAPS-1:0] pix_data,
   input  logic                  pad_mode,
   output logic [OUT_W-1:0]      out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_sof,
   output logic                  line_done,
   output logic [CNT_W-1:0]      line_length,
   output logic [CNT_W-1:0]      line_count,
   output logic                  frame_done,
   output logic                  err_overflow
);

   localparam int BW  = PIX_W * TAPS;
   localparam int R   = ratio(OUT_W, BW);
   localparam int K_W = (R > 1) ? $clog2(R) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   if ((OUT_W % BW) != 0 || R < 1) begin : g_ratio_check
      $error("OUT_W must be a positive multiple of PIX_W*TAPS");
   end

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input int unsigned b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + (CNT_W+1)'(b);
      return s[CNT_W] ? CNT_MAX : s[CNT_W-1:0];
   endfunction

   state_t           state_q, state_d;
   logic [K_W-1:0]   k_q, k_d;
   logic [OUT_W-1:0] word_q, word_d;
   logic [OUT_W-1:0] push_data_q, push_data_d;
   logic             push_pend_q, push_pend_d;
   logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
   logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
   logic [CNT_W-1:0] line_len_q, line_len_d;
   logic             sof_pend_q, sof_pend_d;
   logic             line_end_q, line_end_d;
   logic             frame_end_q, frame_end_d;
   logic             line_done_q, line_done_d;
   logic             frame_done_q, frame_done_d;
   logic             capture, start, finish;
   logic             drop, push_ok;

   assign push_ok = push_pend_q & en & ~drop;

   always_comb begin
      state_d      = state_q;
      k_d          = k_q;
      word_d       = word_q;
      push_data_d  = push_data_q;
      push_pend_d  = 1'b0;
      pix_cnt_d    = pix_cnt_q;
      line_cnt_d   = line_cnt_q;
      line_len_d   = line_len_q;
      sof_pend_d   = sof_pend_q;
      line_end_d   = 1'b0;
      frame_end_d  = 1'b0;
      line_done_d  = line_end_q;
      frame_done_d = frame_end_q;
      start        = 1'b0;
      finish       = 1'b0;
      capture      = fval & lval & dval & (state_q != SYNC);

      // Statistics of a finished line land together with its padded push.
      if (line_end_q) begin
         line_len_d = pix_cnt_q;
         line_cnt_d = sat_add(line_cnt_q, 1);
      end
      if (push_ok) sof_pend_d = 1'b0;

      case (state_q)
         SYNC: if (!fval) state_d = IDLE;
         IDLE: begin
            if (fval) begin
               line_cnt_d = '0;
               sof_pend_d = 1'b1;
               if (lval) begin
                  state_d = LINE;
                  start   = 1'b1;
               end else begin
                  state_d = WAIT_LINE;
               end
            end
         end
         WAIT_LINE: begin
            if (!fval) begin
               state_d     = IDLE;
               frame_end_d = 1'b1;
            end else if (lval) begin
               state_d = LINE;
               start   = 1'b1;
            end
         end
         LINE: begin
            if (!(fval && lval)) begin
               finish      = 1'b1;
               state_d     = fval ? WAIT_LINE : IDLE;
               frame_end_d = ~fval;
            end
         end
         default: state_d = SYNC;
      endcase

      if (start) pix_cnt_d = '0;
      if (capture) begin
         if (k_q == '0) word_d = '0;
         word_d[k_q*BW +: BW] = pix_data;
         pix_cnt_d = sat_add(start ? '0 : pix_cnt_q, TAPS);
         if (k_q == K_W'(R-1)) begin
            push_pend_d = 1'b1;
            push_data_d = word_d;
            k_d         = '0;
         end else begin
            k_d = k_q + 1'b1;
         end
      end
      if (finish) begin
         line_end_d = 1'b1;
         if (k_q != '0 && pad_mode) begin
            push_pend_d = 1'b1;
            push_data_d = word_q;
         end
         k_d = '0;
      end

      if (!en) begin
         state_d      = SYNC;
         k_d          = '0;
         pix_cnt_d    = '0;
         line_cnt_d   = '0;
         sof_pend_d   = 1'b0;
         push_pend_d  = 1'b0;
         line_end_d   = 1'b0;
         frame_end_d  = 1'b0;
         line_done_d  = 1'b0;
         frame_done_d = 1'b0;
      end
   end

   always_ff @(posedge rx_clk) begin
      if (rst) begin
         state_q      <= SYNC;
         k_q          <= '0;
         word_q       <= '0;
         push_data_q  <= '0;
         push_pend_q  <= 1'b0;
         pix_cnt_q    <= '0;
         line_cnt_q   <= '0;
         line_len_q   <= '0;
         sof_pend_q   <= 1'b0;
         line_end_q   <= 1'b0;
         frame_end_q  <= 1'b0;
         line_done_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         k_q          <= k_d;
         word_q       <= word_d;
         push_data_q  <= push_data_d;
         push_pend_q  <= push_pend_d;
         pix_cnt_q    <= pix_cnt_d;
         line_cnt_q   <= line_cnt_d;
         line_len_q   <= line_len_d;
         sof_pend_q   <= sof_pend_d;
         line_end_q   <= line_end_d;
         frame_end_q  <= frame_end_d;
         line_done_q  <= line_done_d;
         frame_done_q <= frame_done_d;
      end
   end

   camlink_out_reg #(.W(OUT_W)) u_out_reg (
      .clk_i      (rx_clk),
      .srst_i     (rst),
      .flush_i    (~en),
      .push_i     (push_pend_q),
      .data_i     (push_data_q),
      .sof_i      (sof_pend_q),
      .ready_i    (out_ready),
      .valid_o    (out_valid),
      .data_o     (out_data),
      .sof_o      (out_sof),
      .drop_o     (drop),
      .overflow_o (err_overflow)
   );

   assign line_done   = line_done_q;
   assign frame_done  = frame_done_q;
   assign line_length = line_len_q;
   assign line_count  = line_cnt_q;

endmodule

// File: tb/tb_camlink_line_packer.sv
// Randomised and directed bench for camlink_line_packer against a line/frame-level reference model.
module tb_camlink_line_packer;

   localparam int PIX_W = 8;
   localparam int TAPS  = 1;
   localparam int OUT_W = 32;
   localparam int CNT_W = 16;
   localparam int BW    = PIX_W * TAPS;
   localparam int R     = OUT_W / BW;
   localparam longint unsigned CMAX = (64'd1 << CNT_W) - 1;

   logic             rx_clk = 1'b0;
   logic             rst = 1'b1, en = 1'b0, fval = 1'b0, lval = 1'b0, dval = 1'b0;
   logic             pad_mode = 1'b1, out_ready = 1'b1;
   logic [BW-1:0]    pix_data = '0;
   logic [OUT_W-1:0] out_data;
   logic             out_valid, out_sof, line_done, frame_done, err_overflow;
   logic [CNT_W-1:0] line_length, line_count;

   always #5 rx_clk = ~rx_clk;

   camlink_line_packer #(.PIX_W(PIX_W), .TAPS(TAPS), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
      .rx_clk(rx_clk), .rst(rst), .en(en), .fval(fval), .lval(lval), .dval(dval),
      .pix_data(pix_data), .pad_mode(pad_mode), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_sof(out_sof), .line_done(line_done),
      .line_length(line_length), .line_count(line_count), .frame_done(frame_done),
      .err_overflow(err_overflow)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (line/frame level) ----------------
   bit               live = 0, m_sync = 0, m_frame = 0, m_line = 0;
   int unsigned      line_pix[$];
   bit               p_push = 0, p_lend = 0, p_fend = 0;
   logic [OUT_W-1:0] p_data = '0;
   longint unsigned  p_len = 0;
   bit               e_valid = 0, e_sof = 0, e_ld = 0, e_fd = 0, e_ovf = 0, sof_pend = 0;
   logic [OUT_W-1:0] e_data = '0;
   longint unsigned  e_len = 0, e_cnt = 0;

   function automatic longint unsigned sat(input longint unsigned v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   // Word made of n pixels of the current line starting at index first, first pixel in LSBs.
   function automatic logic [OUT_W-1:0] pack(input int first, input int n);
      logic [OUT_W-1:0] w = '0;
      for (int j = 0; j < n; j++) w = w | (OUT_W'(line_pix[first+j]) << (BW*j));
      return w;
   endfunction

   task automatic take();
      if (dval) begin
         line_pix.push_back(int'(pix_data));
         if (line_pix.size() % R == 0) begin
            p_push = 1;
            p_data = pack(line_pix.size() - R, R);
         end
      end
   endtask

   task automatic begin_line();
      m_line = 1;
      line_pix.delete();
      take();
   endtask

   task automatic end_line();
      int n = line_pix.size();
      m_line = 0;
      if ((n % R) != 0 && pad_mode) begin
         p_push = 1;
         p_data = pack(n - (n % R), n % R);
      end
      p_lend = 1;
      p_len  = sat(longint'(n) * TAPS);
      if (!fval) begin
         m_frame = 0;
         p_fend  = 1;
      end
   endtask

   task automatic model_step();
      if (rst) begin
         live = 1; m_sync = 0; m_frame = 0; m_line = 0; line_pix.delete();
         p_push = 0; p_lend = 0; p_fend = 0;
         e_valid = 0; e_sof = 0; e_ld = 0; e_fd = 0; e_ovf = 0; sof_pend = 0;
         e_data = '0; e_len = 0; e_cnt = 0;
         return;
      end
      if (!en) begin
         m_sync = 0; m_frame = 0; m_line = 0; line_pix.delete();
         p_push = 0; p_lend = 0; p_fend = 0;
         e_valid = 0; e_ld = 0; e_fd = 0; e_cnt = 0; sof_pend = 0;
         return;
      end
      // events decided on the previous edge take effect now
      e_ld = p_lend;
      e_fd = p_fend;
      if (p_lend) begin
         e_len = p_len;
         e_cnt = sat(e_cnt + 1);
      end
      if (p_push) begin
         if (!e_valid || out_ready) begin
            e_valid = 1; e_data = p_data; e_sof = sof_pend; sof_pend = 0;
         end else begin
            e_ovf = 1;
         end
      end else if (out_ready) begin
         e_valid = 0;
      end
      p_push = 0; p_lend = 0; p_fend = 0;
      // react to this edge's inputs
      if (!m_sync) begin
         if (!fval) m_sync = 1;
      end else if (!m_frame) begin
         if (fval) begin
            m_frame = 1; e_cnt = 0; sof_pend = 1;
            if (lval) begin_line();
         end
      end else if (m_line) begin
         if (fval && lval) take();
         else end_line();
      end else if (!fval) begin
         m_frame = 0;
         p_fend  = 1;
      end else if (lval) begin
         begin_line();
      end
   endtask

   // ---------------- compare process + observation log ----------------
   logic [OUT_W-1:0] acc_d[$];
   bit               acc_s[$];
   int               n_ld = 0, n_fd = 0, n_both = 0;
   longint unsigned  last_len = 0, last_cnt = 0;

   initial begin
      forever begin
         @(posedge rx_clk);
         model_step();
         @(negedge rx_clk);
         if (live) begin
            chk("out_valid", out_valid, e_valid);
            if (e_valid) begin
               chk("out_data", out_data, e_data);
               chk("out_sof", out_sof, e_sof);
            end
            chk("line_done", line_done, e_ld);
            chk("frame_done", frame_done, e_fd);
            chk("line_count", line_count, e_cnt);
            chk("line_length", line_length, e_len);
            chk("err_overflow", err_overflow, e_ovf);
            if (out_valid && out_ready) begin
               acc_d.push_back(out_data);
               acc_s.push_back(out_sof);
               $display("word %08h sof=%0d", out_data, out_sof);
            end
            if (line_done) begin
               n_ld++;
               last_len = line_length;
               last_cnt = line_count;
               $display("line_done length=%0d count=%0d", line_length, line_count);
            end
            if (frame_done) n_fd++;
            if (frame_done && line_done) n_both++;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   bit rnd_ready = 0;

   task automatic drive(input bit f, input bit l, input bit d, input logic [BW-1:0] px);
      fval = f; lval = l; dval = d; pix_data = px;
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
      @(posedge rx_clk);
      #1;
   endtask

   // mode 0: dval always 1, mode 1: alternating, mode 2: random
   task automatic send_line(input int n, input bit seq, input int mode, input bit close_frame);
      int i = 0;
      bit alt = 0;
      bit d;
      while (i < n) begin
         d   = (mode == 0) ? 1'b1 : (mode == 1) ? alt : bit'($urandom_range(0, 1));
         alt = !alt;
         drive(1, 1, d, seq ? BW'(i + 1) : BW'($urandom));
         if (d) i++;
      end
      if (close_frame) drive(0, 0, 0, '0);
      else begin
         drive(1, 0, 0, '0);
         drive(1, 0, 0, '0);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) drive(0, 0, 0, '0);
   endtask

   task automatic frame1(input int npix, input int mode);
      drive(1, 0, 0, '0);
      send_line(npix, 1, mode, 0);
      idle(4);
   endtask

   task automatic clear_log();
      acc_d.delete(); acc_s.delete();
      n_ld = 0; n_fd = 0; n_both = 0;
   endtask

   task automatic chk_words(input string tag, input int n, input logic [31:0] w0, input logic [31:0] w1);
      chk({tag, "_nwords"}, acc_d.size(), n);
      if (acc_d.size() >= 1) begin
         chk({tag, "_w0"}, acc_d[0], w0);
         chk({tag, "_sof0"}, acc_s[0], 1);
      end
      if (n >= 2 && acc_d.size() >= 2) begin
         chk({tag, "_w1"}, acc_d[1], w1);
         chk({tag, "_sof1"}, acc_s[1], 0);
      end
   endtask

   initial begin
      idle(3);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_line_count", line_count, 0);
      chk("rst_err", err_overflow, 0);
      rst = 0; en = 1;
      idle(3);

      // 1: plain 8-pixel line
      clear_log(); frame1(8, 0);
      chk_words("s1", 2, 32'h04030201, 32'h08070605);
      chk("s1_len", last_len, 8); chk("s1_cnt", last_cnt, 1); chk("s1_fd", n_fd, 1);

      // 2: 6-pixel line padded / discarded
      clear_log(); pad_mode = 1; frame1(6, 0);
      chk_words("s2pad", 2, 32'h04030201, 32'h00000605);
      chk("s2pad_len", last_len, 6);
      clear_log(); pad_mode = 0; frame1(6, 0);
      chk_words("s2nopad", 1, 32'h04030201, 32'h0);
      chk("s2nopad_len", last_len, 6);
      pad_mode = 1;

      // 3: alternating dval
      clear_log(); frame1(8, 1);
      chk_words("s3", 2, 32'h04030201, 32'h08070605);
      chk("s3_len", last_len, 8);

      // 4: consumer stalled across the line
      clear_log(); out_ready = 0; frame1(8, 0);
      chk("s4_held_valid", out_valid, 1);
      chk("s4_held_data", out_data, 32'h04030201);
      chk("s4_ovf", err_overflow, 1);
      out_ready = 1; idle(3);
      chk_words("s4", 1, 32'h04030201, 32'h0);
      chk("s4_ovf_sticky", err_overflow, 1);
      rst = 1; idle(2); rst = 0;
      chk("s4_ovf_rst", err_overflow, 0);
      idle(2);

      // 5: en dropped mid-line, raised again inside the frame
      clear_log();
      drive(1, 0, 0, '0);
      for (int i = 1; i <= 6; i++) drive(1, 1, 1, BW'(i));
      en = 0; drive(1, 1, 1, 8'd7); drive(1, 1, 1, 8'd8);
      en = 1;
      for (int i = 9; i <= 12; i++) drive(1, 1, 1, BW'(i));
      drive(1, 0, 0, '0); send_line(8, 1, 0, 0); idle(4);
      chk_words("s5a", 1, 32'h04030201, 32'h0);
      chk("s5a_lines", n_ld, 0); chk("s5a_frames", n_fd, 0);
      clear_log(); frame1(8, 0);
      chk_words("s5b", 2, 32'h04030201, 32'h08070605);

      // 6: fval and lval fall together
      clear_log();
      drive(1, 0, 0, '0); send_line(5, 1, 0, 1); idle(4);
      chk_words("s6", 2, 32'h04030201, 32'h00000005);
      chk("s6_both", n_both, 1); chk("s6_cnt", last_cnt, 1); chk("s6_len", last_len, 5);

      // random frames with random back-pressure
      rnd_ready = 1;
      for (int f = 0; f < 40; f++) begin
         int nl = $urandom_range(1, 3);
         pad_mode = bit'($urandom_range(0, 1));
         drive(1, 0, 0, '0);
         for (int l = 0; l < nl; l++)
            send_line($urandom_range(1, 11), 0, $urandom_range(0, 2),
                      (l == nl - 1) && ($urandom_range(0, 3) == 0));
         idle($urandom_range(3, 5));
      end
      rnd_ready = 0; out_ready = 1;
      idle(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
